// File: rtl/mcc_seq_wide_adder.sv
// Sequential wide adder: WIDTH-bit operands are summed CHUNK bits per cycle through
// one Manchester-carry-chain slice adder, with the slice carry held in a register.

module AdderBlock64bit #(
    parameter int size = 64
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            cin,
    output logic [size-1:0] s,
    output logic            cout
);
    logic [size-1:0] p;
    logic [size-1:0] g;
    logic [size:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Static carry chain: each node either generates, passes (propagate) or kills.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < size; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s    = p ^ c[size-1:0];
    assign cout = c[size];
endmodule

module mcc_seq_wide_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_co;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                sl_a = a_q[i*CHUNK +: CHUNK];
                sl_b = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    AdderBlock64bit #(.size(CHUNK)) u_mcc (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) sum_d[i*CHUNK +: CHUNK] = sl_s;
                end
                carry_d = sl_co;
                if (idx_q == IDX_LAST) cout_d = sl_co;
                else                   idx_d  = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_mcc_seq_wide_adder.sv
// Bench for mcc_seq_wide_adder: directed vector table, backpressure and reset sequences,
// and scoreboard-checked random traffic on a 64/16 and a 32/8 instance.

module tb_mcc_seq_wide_adder;
    localparam int N64 = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid64, in_ready64, cin64, out_valid64, out_ready64, cout64, busy64;
    logic [63:0] a64, b64, sum64;
    logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32, cout32, busy32;
    logic [31:0] a32, b32, sum32;

    mcc_seq_wide_adder #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .cin(cin64), .out_valid(out_valid64), .out_ready(out_ready64),
        .sum(sum64), .cout(cout64), .busy(busy64)
    );

    mcc_seq_wide_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .cout(cout32), .busy(busy32)
    );

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_in_ready(input bit sel);
        return sel ? in_ready32 : in_ready64;
    endfunction

    function automatic logic get_out_valid(input bit sel);
        return sel ? out_valid32 : out_valid64;
    endfunction

    function automatic logic [64:0] get_result(input bit sel);
        return sel ? {32'b0, cout32, sum32} : {cout64, sum64};
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [63:0] x,
                          input logic [63:0] y, input logic c);
        if (sel) begin
            in_valid32 = v; a32 = x[31:0]; b32 = y[31:0]; cin32 = c;
        end else begin
            in_valid64 = v; a64 = x; b64 = y; cin64 = c;
        end
    endtask

    task automatic set_out_ready(input bit sel, input logic r);
        if (sel) out_ready32 = r;
        else     out_ready64 = r;
    endtask

    // Issue one operation on the 64-bit instance from IDLE; returns at the first out_valid cycle.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                         output logic [63:0] rs, output logic rc, output int lat);
        set_in(0, 1'b1, ta, tb_, tc);
        step;
        in_valid64 = 1'b0;
        lat = 0;
        while (!out_valid64 && lat < 40) begin
            step;
            lat++;
        end
        rs = sum64;
        rc = cout64;
    endtask

    task automatic rand_run(input bit sel, input int nops);
        logic [63:0] qa[$], qb[$];
        logic        qc[$];
        logic [63:0] mask, va, vb;
        logic        vc, orr;
        logic [64:0] e;
        int          sent, got, gap, w, cyc;
        bit          stuck;
        string       nm;
        mask  = sel ? 64'h0000_0000_FFFF_FFFF : '1;
        nm    = sel ? "rand32" : "rand64";
        sent  = 0;
        got   = 0;
        stuck = 0;
        fork
            begin
                while (sent < nops && !stuck) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) step;
                    va = {$urandom, $urandom} & mask;
                    vb = {$urandom, $urandom} & mask;
                    vc = 1'($urandom_range(0, 1));
                    set_in(sel, 1'b1, va, vb, vc);
                    w = 0;
                    while (!get_in_ready(sel) && w < 100) begin
                        step;
                        w++;
                    end
                    if (w >= 100) begin
                        stuck = 1;
                        chk({nm, "_accept_timeout"}, 65'(w), 65'd0);
                    end else begin
                        qa.push_back(va);
                        qb.push_back(vb);
                        qc.push_back(vc);
                        sent++;
                        step;
                    end
                    set_in(sel, 1'b0, '0, '0, 1'b0);
                end
            end
            begin
                cyc = 0;
                while (got < sent + (stuck ? 0 : nops - sent) && cyc < nops * 40) begin
                    orr = 1'($urandom_range(0, 1));
                    set_out_ready(sel, orr);
                    if (get_out_valid(sel) && orr) begin
                        if (qa.size() == 0) begin
                            chk({nm, "_unexpected_result"}, get_result(sel), 65'h0);
                        end else begin
                            e = {1'b0, qa.pop_front()} + {1'b0, qb.pop_front()} + 65'(qc.pop_front());
                            if (sel) e = {32'b0, e[32:0]};
                            chk(nm, get_result(sel), e);
                        end
                        got++;
                    end
                    step;
                    cyc++;
                end
                chk({nm, "_results_received"}, 65'(got), 65'(nops));
            end
        join
        set_out_ready(sel, 1'b0);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        co;
    } vec_t;

    vec_t        vt[5];
    logic [63:0] rs;
    logic        rc;
    logic [64:0] e;
    int          lat;

    initial begin
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vt[1] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vt[3] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0};
        vt[4] = '{64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0F0F, 1'b1, 64'h0000_0000_0000_1000, 1'b0};

        rst_n = 1'b0;
        set_in(0, 1'b0, '0, '0, 1'b0);
        set_in(1, 1'b0, '0, '0, 1'b0);
        out_ready64 = 1'b0;
        out_ready32 = 1'b0;
        #1;
        chk("rst_in_ready", 65'(in_ready64), 65'd1);
        chk("rst_out_valid", 65'(out_valid64), 65'd0);
        chk("rst_busy", 65'(busy64), 65'd0);
        chk("rst_sum_cout", {cout64, sum64}, 65'd0);
        chk("rst32_sum_cout", {32'b0, cout32, sum32}, 65'd0);
        step;
        step;
        rst_n = 1'b1;
        step;

        out_ready64 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].cin, rs, rc, lat);
            chk($sformatf("vec%0d_latency", i), 65'(lat), 65'(N64));
            chk($sformatf("vec%0d_sum", i), 65'(rs), 65'(vt[i].s));
            chk($sformatf("vec%0d_cout", i), 65'(rc), 65'(vt[i].co));
            step;
            chk($sformatf("vec%0d_valid_one_cycle", i), 65'(out_valid64), 65'd0);
            chk($sformatf("vec%0d_ready_back", i), 65'(in_ready64), 65'd1);
        end

        out_ready64 = 1'b0;
        e = {1'b0, 64'h1111_2222_3333_4444} + {1'b0, 64'h0F0F_F0F0_0F0F_F0F0} + 65'd1;
        do_op(64'h1111_2222_3333_4444, 64'h0F0F_F0F0_0F0F_F0F0, 1'b1, rs, rc, lat);
        chk("bp_latency", 65'(lat), 65'(N64));
        for (int c = 0; c < 10; c++) begin
            if (c == 2) set_in(0, 1'b1, '1, '1, 1'b1);
            chk($sformatf("bp%0d_result", c), {cout64, sum64}, e);
            chk($sformatf("bp%0d_in_ready", c), 65'(in_ready64), 65'd0);
            chk($sformatf("bp%0d_busy", c), 65'(busy64), 65'd1);
            chk($sformatf("bp%0d_out_valid", c), 65'(out_valid64), 65'd1);
            step;
        end
        set_in(0, 1'b0, '0, '0, 1'b0);
        out_ready64 = 1'b1;
        step;
        chk("bp_release_idle", 65'(in_ready64), 65'd1);
        chk("bp_release_valid", 65'(out_valid64), 65'd0);
        repeat (8) step;
        chk("bp_intruder_dropped", {63'b0, out_valid64, busy64}, 65'd0);

        set_in(0, 1'b1, '1, 64'h0, 1'b0);
        step;
        set_in(0, 1'b0, '0, '0, 1'b0);
        step;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 65'(in_ready64), 65'd1);
        chk("mid_rst_out_valid", 65'(out_valid64), 65'd0);
        chk("mid_rst_busy", 65'(busy64), 65'd0);
        chk("mid_rst_sum_cout", {cout64, sum64}, 65'd0);
        #3;
        rst_n = 1'b1;
        step;
        do_op(64'd1, 64'd2, 1'b0, rs, rc, lat);
        chk("post_rst_latency", 65'(lat), 65'(N64));
        chk("post_rst_result", {rc, rs}, 65'd3);
        step;

        out_ready64 = 1'b0;
        rand_run(0, 2000);
        rand_run(1, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
